// File: rtl/ssd_arb_pkg.sv
// Shared types and defaults for the seven-segment display arbiter.
// Defines the FSM state encoding, default timing constants and the owner index width.
package ssd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW     = 2'd1,
    OVERRIDE = 2'd2
  } arb_state_e;

  localparam int DWELL_DEF    = 2000;
  localparam int OVR_HOLD_DEF = 500;
  localparam int OWNER_W      = 2;

endpackage

// File: rtl/ssd_display_arbiter_if.sv
// Source/display bundle between the value sources and the arbiter.
// The sources side is the master; the arbiter side is the slave.
interface ssd_display_arbiter_if
  import ssd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 10
);
  // REQ[i] is a level request held by source i for as long as it wants display
  // time; GNT is the registered one-hot answer, and VAL[i] is sampled only while
  // GNT[i] is set. There is no back-pressure: ownership changes take effect
  // one DCLK after the decision.
  logic [NREQ-1:0]    REQ;
  logic [NREQ*W-1:0]  VAL;
  logic               OVR_REQ;
  logic [W-1:0]       OVR_VAL;
  logic [W-1:0]       DIN_OUT;
  logic [NREQ-1:0]    GNT;
  logic [OWNER_W-1:0] OWNER;
  logic               SWITCH;
  logic               OVR_ACT;

  modport master (
    output REQ, VAL, OVR_REQ, OVR_VAL,
    input  DIN_OUT, GNT, OWNER, SWITCH, OVR_ACT
  );

  modport slave (
    input  REQ, VAL, OVR_REQ, OVR_VAL,
    output DIN_OUT, GNT, OWNER, SWITCH, OVR_ACT
  );
endinterface

// File: rtl/ssd_display_arbiter_rr_pick.sv
// Round-robin search: first set request at or after start_i, wrapping modulo NREQ.
// Purely combinational; the arbiter feeds it owner+1 so the current owner is checked last.
module rr_pick
  import ssd_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [OWNER_W-1:0] start_i,
  output logic               found_o,
  output logic [OWNER_W-1:0] idx_o
);

  // Walk from the far end back towards start_i so the closest requester wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(start_i) + k) % NREQ]) begin
        found_o = 1'b1;
        idx_o   = OWNER_W'((int'(start_i) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Time-shares the 4-digit display between NREQ sources in round-robin order,
// with a level override that pre-empts the rotation and freezes the dwell count.
module ssd_display_arbiter
  import ssd_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int W        = 10,
  parameter int DWELL    = DWELL_DEF,
  parameter int OVR_HOLD = OVR_HOLD_DEF
) (
  input  logic                 DCLK,
  input  logic                 RST,
  ssd_display_arbiter_if.slave bus,
  output logic [1:0]           state_o
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int HW = $clog2(OVR_HOLD + 1);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SHOW = SHOW;
  localparam logic [1:0] S_OVR  = OVERRIDE;

  logic [1:0]         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d, start_idx, pick_idx;
  logic               pick_found, do_pick;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               resume_q, resume_d;
  logic [W-1:0]       din_q, din_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               switch_q, switch_d;
  logic               ovr_q, ovr_d;
  logic [W-1:0]       val_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) val_arr[i] = bus.VAL[i*W +: W];
  end

  assign start_idx = (owner_q == OWNER_W'(NREQ - 1)) ? '0 : owner_q + OWNER_W'(1);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (bus.REQ),
    .start_i (start_idx),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // resume_q remembers whether the override interrupted a live grant, so an
  // override entered from IDLE never resurrects a stale owner.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    dwell_d  = dwell_q;
    hold_d   = hold_q;
    resume_d = resume_q;
    switch_d = 1'b0;
    do_pick  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.OVR_REQ) begin
          state_d  = S_OVR;
          hold_d   = '0;
          resume_d = 1'b0;
        end else begin
          do_pick = 1'b1;
        end
      end
      S_SHOW: begin
        if (bus.OVR_REQ) begin
          state_d  = S_OVR;
          hold_d   = '0;
          resume_d = 1'b1;
        end else if (dwell_q == DW'(DWELL - 1) || !bus.REQ[owner_q]) begin
          do_pick = 1'b1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      S_OVR: begin
        if (bus.OVR_REQ || hold_q < HW'(OVR_HOLD - 1)) begin
          hold_d = (hold_q == HW'(OVR_HOLD)) ? hold_q : hold_q + HW'(1);
        end else if (resume_q && bus.REQ[owner_q]) begin
          state_d = S_SHOW;
        end else begin
          do_pick = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_pick) begin
      dwell_d = '0;
      if (pick_found) begin
        state_d  = S_SHOW;
        owner_d  = pick_idx;
        switch_d = (pick_idx != owner_q);
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Outputs are a function of the next state so they land in the same register stage.
  always_comb begin
    gnt_d = '0;
    din_d = '0;
    ovr_d = 1'b0;
    case (state_d)
      S_SHOW: begin
        gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
        din_d = val_arr[owner_d];
      end
      S_OVR: begin
        din_d = bus.OVR_VAL;
        ovr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      owner_q  <= OWNER_W'(NREQ - 1);
      dwell_q  <= '0;
      hold_q   <= '0;
      resume_q <= 1'b0;
      din_q    <= '0;
      gnt_q    <= '0;
      switch_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      dwell_q  <= dwell_d;
      hold_q   <= hold_d;
      resume_q <= resume_d;
      din_q    <= din_d;
      gnt_q    <= gnt_d;
      switch_q <= switch_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.DIN_OUT = din_q;
  assign bus.GNT     = gnt_q;
  assign bus.OWNER   = owner_q;
  assign bus.SWITCH  = switch_q;
  assign bus.OVR_ACT = ovr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter: constant vector table, hand-written override and
// rotation sequences, and randomized traffic against a tick-level reference model.
module tb_ssd_display_arbiter;
  import ssd_arb_pkg::*;

  localparam int NREQ     = 4;
  localparam int W        = 10;
  localparam int DWELL    = 4;
  localparam int OVR_HOLD = 3;
  localparam int OW       = W + NREQ + 2 + 1 + 1;

  // ---------------- clock / reset ----------------
  logic       DCLK = 1'b0;
  logic       RST  = 1'b1;
  logic [1:0] state_dbg;

  always #5 DCLK = ~DCLK;

  ssd_display_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  ssd_display_arbiter #(
    .NREQ(NREQ), .W(W), .DWELL(DWELL), .OVR_HOLD(OVR_HOLD)
  ) dut (
    .DCLK    (DCLK),
    .RST     (RST),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the displayed source and the ticks it still has left, rather than a counter.
  bit         m_show, m_ovr, m_paused, m_sw;
  int         m_owner, m_left, m_shown;
  logic [W-1:0]    m_din;
  logic [NREQ-1:0] m_gnt;

  function automatic int find_next(input logic [NREQ-1:0] req, input int from);
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic grant_next(input logic [NREQ-1:0] req);
    int n;
    n = find_next(req, m_owner);
    if (n < 0) begin
      m_show = 1'b0;
    end else begin
      m_sw    = (n != m_owner);
      m_owner = n;
      m_show  = 1'b1;
      m_left  = DWELL;
    end
  endtask

  task automatic model_step(input logic rst, input logic [NREQ-1:0] req,
                            input logic [NREQ*W-1:0] val, input logic ovr,
                            input logic [W-1:0] ov);
    m_sw = 1'b0;
    if (rst) begin
      m_show = 0; m_ovr = 0; m_paused = 0;
      m_owner = NREQ - 1; m_left = 0; m_shown = 0;
    end else if (m_ovr) begin
      if (ovr || m_shown < OVR_HOLD) begin
        m_shown++;
      end else begin
        m_ovr = 1'b0;
        if (m_paused && req[m_owner]) m_show = 1'b1;
        else grant_next(req);
      end
    end else if (ovr) begin
      m_ovr    = 1'b1;
      m_shown  = 1;
      m_paused = m_show;
      m_show   = 1'b0;
    end else if (m_show) begin
      if (m_left == 1 || !req[m_owner]) grant_next(req);
      else m_left--;
    end else begin
      grant_next(req);
    end
    m_gnt = m_show ? (NREQ'(1) << m_owner) : '0;
    m_din = m_ovr ? ov : (m_show ? val[m_owner*W +: W] : '0);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic rst, input logic [NREQ-1:0] req,
                     input logic [NREQ*W-1:0] val, input logic ovr, input logic [W-1:0] ov);
    logic [OW-1:0] act, exp;
    @(negedge DCLK);
    RST         = rst;
    bus.REQ     = req;
    bus.VAL     = val;
    bus.OVR_REQ = ovr;
    bus.OVR_VAL = ov;
    model_step(rst, req, val, ovr, ov);
    exp_q.push_back({m_din, m_gnt, 2'(m_owner), m_sw, m_ovr});
    @(posedge DCLK);
    #1;
    act = {bus.DIN_OUT, bus.GNT, bus.OWNER, bus.SWITCH, bus.OVR_ACT};
    exp = exp_q.pop_front();
    check("model", 32'(act), 32'(exp));
  endtask

  task automatic expect_out(input string nm, input logic [NREQ-1:0] gnt,
                            input logic [W-1:0] din, input logic sw, input logic oa);
    check({nm, ".gnt"}, 32'(bus.GNT), 32'(gnt));
    check({nm, ".din"}, 32'(bus.DIN_OUT), 32'(din));
    check({nm, ".sw"},  32'(bus.SWITCH), 32'(sw));
    check({nm, ".oa"},  32'(bus.OVR_ACT), 32'(oa));
  endtask

  task automatic do_reset(input logic [NREQ*W-1:0] val);
    cyc(1'b1, '0, val, 1'b0, '0);
    cyc(1'b1, '0, val, 1'b0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    din;
    logic            sw;
  } vec_t;

  vec_t tbl[13];

  localparam logic [NREQ*W-1:0] V4 = {10'd40, 10'd30, 10'd20, 10'd10};

  initial begin
    logic [NREQ*W-1:0] v3, rv;
    logic [NREQ-1:0]   rreq;
    int ovr_left;

    bus.REQ = '0; bus.VAL = '0; bus.OVR_REQ = 1'b0; bus.OVR_VAL = '0;

    // REQ=1011: owners 0,1,3 for four ticks each, then back to 0
    for (int i = 0; i < 13; i++) begin
      tbl[i].req = 4'b1011;
      case ((i / 4) % 3)
        0:       begin tbl[i].gnt = 4'b0001; tbl[i].din = 10'd10; end
        1:       begin tbl[i].gnt = 4'b0010; tbl[i].din = 10'd20; end
        default: begin tbl[i].gnt = 4'b1000; tbl[i].din = 10'd40; end
      endcase
      tbl[i].sw = (i % 4 == 0);
    end

    // 1: reset mid-SHOW
    do_reset(V4);
    check("rst.state", 32'(state_dbg), 32'(IDLE));
    check("rst.owner", 32'(bus.OWNER), 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, V4, 1'b0, '0);
    cyc(1'b1, 4'b1111, V4, 1'b0, '0);
    expect_out("rst_mid", 4'b0000, 10'd0, 1'b0, 1'b0);
    check("rst_mid.owner", 32'(bus.OWNER), 32'd3);

    // 2: table-driven round robin
    do_reset(V4);
    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].req, V4, 1'b0, '0);
      expect_out($sformatf("rr%0d", i), tbl[i].gnt, tbl[i].din, tbl[i].sw, 1'b0);
    end

    // 3: lone requester re-grants itself, then drops to IDLE
    v3 = '0;
    v3[29:20] = 10'd999;
    do_reset(v3);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0100, v3, 1'b0, '0);
      expect_out($sformatf("solo%0d", i), 4'b0100, 10'd999, (i == 0), 1'b0);
    end
    cyc(1'b0, 4'b0000, v3, 1'b0, '0);
    expect_out("solo_drop", 4'b0000, 10'd0, 1'b0, 1'b0);
    check("solo_drop.state", 32'(state_dbg), 32'(IDLE));
    check("solo_drop.owner", 32'(bus.OWNER), 32'd2);

    // 4: short override mid-dwell; owner 0 resumes for its remaining 2 ticks
    do_reset(V4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1011, V4, 1'b0, '0);
    cyc(1'b0, 4'b1011, V4, 1'b1, 10'd777);
    expect_out("ovr4_0", 4'b0000, 10'd777, 1'b0, 1'b1);
    for (int i = 1; i < 3; i++) begin
      cyc(1'b0, 4'b1011, V4, 1'b0, 10'd777);
      expect_out($sformatf("ovr4_%0d", i), 4'b0000, 10'd777, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 4'b1011, V4, 1'b0, '0);
      expect_out($sformatf("res4_%0d", i), 4'b0001, 10'd10, 1'b0, 1'b0);
    end
    cyc(1'b0, 4'b1011, V4, 1'b0, '0);
    expect_out("rot4", 4'b0010, 10'd20, 1'b1, 1'b0);

    // 5: override on the expiry tick, held 6 ticks; one resumed tick then rotation
    do_reset(V4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b1011, V4, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'b1011, V4, 1'b1, 10'd555);
      expect_out($sformatf("ovr5_%0d", i), 4'b0000, 10'd555, 1'b0, 1'b1);
    end
    cyc(1'b0, 4'b1011, V4, 1'b0, '0);
    expect_out("res5", 4'b0001, 10'd10, 1'b0, 1'b0);
    cyc(1'b0, 4'b1011, V4, 1'b0, '0);
    expect_out("rot5", 4'b0010, 10'd20, 1'b1, 1'b0);

    // 6: owner 1 withdraws mid-dwell; search continues from index 2
    do_reset(V4);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1011, V4, 1'b0, '0);
    cyc(1'b0, 4'b1001, V4, 1'b0, '0);
    expect_out("drop6", 4'b1000, 10'd40, 1'b1, 1'b0);
    check("drop6.owner", 32'(bus.OWNER), 32'd3);

    // randomized traffic against the model
    do_reset(V4);
    rreq = 4'b1011;
    ovr_left = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      if (ovr_left == 0 && $urandom_range(0, 19) == 0) ovr_left = $urandom_range(1, 7);
      rv[31:0]  = $urandom;
      rv[39:32] = 8'($urandom);
      cyc(($urandom_range(0, 149) == 0), rreq, rv, (ovr_left > 0), 10'($urandom));
      if (ovr_left > 0) ovr_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
